axis_packet_stats: RTL and testbench

AXIS_PACKET_STATS -- requirements
Module: axis_packet_stats

---
 rtl/axis_packet_stats_pkg.sv | 26 ++
 rtl/axis_packet_stats_if.sv | 13 +
 rtl/axis_packet_stats_keep_popcount.sv | 29 ++
 rtl/axis_packet_stats.sv | 156 +++++++++++++++
 tb/tb_axis_packet_stats.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_packet_stats_pkg.sv
// Shared definitions for the AXI-Stream packet statistics block:
// FSM encoding and a width-generic saturating adder for the counters.
package axis_packet_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_IN_PKT = 2'd2
    } state_t;

    localparam int SAT_W_MIN = 16;
    localparam int SAT_W_MAX = 48;
    localparam logic [SAT_W_MAX:0] SAT_ONE_X = 1;

    // Adds in SAT_W_MAX+1 bits and clamps to the all-ones value of a w-bit counter.
    function automatic logic [SAT_W_MAX-1:0] sat_add(input logic [SAT_W_MAX-1:0] a,
                                                     input logic [SAT_W_MAX-1:0] b,
                                                     input int unsigned w);
        logic [SAT_W_MAX:0] sum;
        logic [SAT_W_MAX:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (SAT_ONE_X << w) - SAT_ONE_X;
        return (sum > lim) ? lim[SAT_W_MAX-1:0] : sum[SAT_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/axis_packet_stats_if.sv
// AXI-Stream sink bundle observed by the packet statistics block.
interface axis_packet_stats_if #(
    parameter int BYTES = 32
);
    logic [8*BYTES-1:0] tdata;
    logic [BYTES-1:0]   tkeep;
    logic               tvalid;
    logic               tlast;
    logic               tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_stats_keep_popcount.sv
// Combinational population count of a tkeep vector, built as a balanced
// binary adder tree with one separate signal array per tree level.
module keep_popcount #(
    parameter int  BYTES = 32,
    localparam int LVLS  = $clog2(BYTES),
    localparam int CW    = $clog2(BYTES) + 1
) (
    input  logic [BYTES-1:0] keep,
    output logic [CW-1:0]    count
);
    genvar gl;
    genvar gi;
    generate
        for (gl = 0; gl <= LVLS; gl++) begin : g_lvl
            logic [CW-1:0] s [BYTES >> gl];
            if (gl == 0) begin : g_leaf
                for (gi = 0; gi < BYTES; gi++) begin : g_bit
                    assign s[gi] = CW'(keep[gi]);
                end
            end else begin : g_sum
                for (gi = 0; gi < (BYTES >> gl); gi++) begin : g_add
                    assign s[gi] = g_lvl[gl-1].s[2*gi] + g_lvl[gl-1].s[2*gi+1];
                end
            end
        end
    endgenerate

    assign count = g_lvl[LVLS].s[0];
endmodule

// File: rtl/axis_packet_stats.sv
// AXI-Stream sink that accepts packets and maintains saturating per-packet
// statistics (count, last/min/max size, malformed-tkeep errors).
module axis_packet_stats
    import axis_packet_stats_pkg::*;
#(
    parameter int BYTES = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 resent,
    axis_packet_stats_if.slave   axisin,
    input  logic                 stall,
    input  logic                 clear,
    output logic [CNT_W-1:0]     packet_count,
    output logic [CNT_W-1:0]     last_pkt_bytes,
    output logic [CNT_W-1:0]     last_pkt_beats,
    output logic [CNT_W-1:0]     max_pkt_bytes,
    output logic [CNT_W-1:0]     min_pkt_bytes,
    output logic [CNT_W-1:0]     err_count,
    output logic                 stats_valid
);
    localparam int CW = $clog2(BYTES) + 1;

    state_t           state_q, state_d;
    logic             tready_q, tready_d;
    logic [CNT_W-1:0] beats_q, beats_d, bytes_q, bytes_d;
    logic             err_q, err_d, seen_q, seen_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, last_bytes_q, last_bytes_d;
    logic [CNT_W-1:0] last_beats_q, last_beats_d, max_q, max_d, min_q, min_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             stats_valid_q, stats_valid_d;

    logic [CW-1:0]    pop_cnt;
    logic [BYTES-1:0] keep_p1;
    logic             accept, beat_err, pkt_err;
    logic [CNT_W-1:0] tot_bytes, tot_beats;
    logic             unused_tdata;

    assign unused_tdata = ^axisin.tdata;

    keep_popcount #(.BYTES(BYTES)) u_popcount (
        .keep  (axisin.tkeep),
        .count (pop_cnt)
    );

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        bytes_d       = bytes_q;
        err_d         = err_q;
        seen_d        = seen_q;
        pkt_cnt_d     = pkt_cnt_q;
        last_bytes_d  = last_bytes_q;
        last_beats_d  = last_beats_q;
        max_d         = max_q;
        min_d         = min_q;
        err_cnt_d     = err_cnt_q;
        stats_valid_d = 1'b0;

        accept    = axisin.tvalid && tready_q;
        keep_p1   = axisin.tkeep + BYTES'(1);
        // A closing beat must be a non-empty run of ones starting at byte 0.
        beat_err  = axisin.tlast
                  ? !((axisin.tkeep != '0) && ((axisin.tkeep & keep_p1) == '0))
                  : (axisin.tkeep != '1);
        pkt_err   = err_q || beat_err;
        tot_bytes = CNT_W'(sat_add(SAT_W_MAX'(bytes_q), SAT_W_MAX'(pop_cnt), CNT_W));
        tot_beats = CNT_W'(sat_add(SAT_W_MAX'(beats_q), SAT_W_MAX'(1), CNT_W));

        case (state_q)
            ST_IDLE: state_d = ST_READY;
            ST_READY, ST_IN_PKT: begin
                if (accept && !axisin.tlast) begin
                    beats_d = tot_beats;
                    bytes_d = tot_bytes;
                    err_d   = pkt_err;
                    state_d = ST_IN_PKT;
                end else if (accept) begin
                    pkt_cnt_d    = CNT_W'(sat_add(SAT_W_MAX'(pkt_cnt_q), SAT_W_MAX'(1), CNT_W));
                    last_bytes_d = tot_bytes;
                    last_beats_d = tot_beats;
                    if (tot_bytes > max_q) max_d = tot_bytes;
                    if (!seen_q || tot_bytes < min_q) min_d = tot_bytes;
                    if (pkt_err)
                        err_cnt_d = CNT_W'(sat_add(SAT_W_MAX'(err_cnt_q), SAT_W_MAX'(1), CNT_W));
                    seen_d        = 1'b1;
                    stats_valid_d = 1'b1;
                    beats_d       = '0;
                    bytes_d       = '0;
                    err_d         = 1'b0;
                    state_d       = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear wins over any beat accepted in the same cycle, which is dropped.
        if (clear) begin
            state_d       = ST_READY;
            beats_d       = '0;
            bytes_d       = '0;
            err_d         = 1'b0;
            seen_d        = 1'b0;
            pkt_cnt_d     = '0;
            last_bytes_d  = '0;
            last_beats_d  = '0;
            max_d         = '0;
            min_d         = '0;
            err_cnt_d     = '0;
            stats_valid_d = 1'b0;
        end

        tready_d = (state_d != ST_IDLE) && !stall;
    end

    always_ff @(posedge clk or posedge resent) begin
        if (resent) begin
            state_q       <= ST_IDLE;
            tready_q      <= 1'b0;
            beats_q       <= '0;
            bytes_q       <= '0;
            err_q         <= 1'b0;
            seen_q        <= 1'b0;
            pkt_cnt_q     <= '0;
            last_bytes_q  <= '0;
            last_beats_q  <= '0;
            max_q         <= '0;
            min_q         <= '0;
            err_cnt_q     <= '0;
            stats_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tready_q      <= tready_d;
            beats_q       <= beats_d;
            bytes_q       <= bytes_d;
            err_q         <= err_d;
            seen_q        <= seen_d;
            pkt_cnt_q     <= pkt_cnt_d;
            last_bytes_q  <= last_bytes_d;
            last_beats_q  <= last_beats_d;
            max_q         <= max_d;
            min_q         <= min_d;
            err_cnt_q     <= err_cnt_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    assign axisin.tready  = tready_q;
    assign packet_count   = pkt_cnt_q;
    assign last_pkt_bytes = last_bytes_q;
    assign last_pkt_beats = last_beats_q;
    assign max_pkt_bytes  = max_q;
    assign min_pkt_bytes  = min_q;
    assign err_count      = err_cnt_q;
    assign stats_valid    = stats_valid_q;
endmodule

// File: tb/tb_axis_packet_stats.sv
// Directed bench for axis_packet_stats: one 32-bit-counter instance for the
// functional cases and one 16-bit-counter instance for saturation.
module tb_axis_packet_stats;
    localparam int BYTES = 32;
    localparam int CW32  = 32;
    localparam int CW16  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1, rst16 = 1'b1;
    logic stall = 1'b0, clear = 1'b0, stall16 = 1'b0, clear16 = 1'b0;
    always #5 clk = ~clk;

    axis_packet_stats_if #(.BYTES(BYTES)) s_if ();
    axis_packet_stats_if #(.BYTES(BYTES)) s16_if ();

    logic [CW32-1:0] packet_count, last_pkt_bytes, last_pkt_beats, max_pkt_bytes, min_pkt_bytes, err_count;
    logic            stats_valid;
    logic [CW16-1:0] pc16, lb16, lbe16, mx16, mn16, er16;
    logic            sv16;

    axis_packet_stats #(.BYTES(BYTES), .CNT_W(CW32)) dut (
        .clk(clk), .resent(rst), .axisin(s_if), .stall(stall), .clear(clear),
        .packet_count(packet_count), .last_pkt_bytes(last_pkt_bytes),
        .last_pkt_beats(last_pkt_beats), .max_pkt_bytes(max_pkt_bytes),
        .min_pkt_bytes(min_pkt_bytes), .err_count(err_count), .stats_valid(stats_valid)
    );

    axis_packet_stats #(.BYTES(BYTES), .CNT_W(CW16)) dut16 (
        .clk(clk), .resent(rst16), .axisin(s16_if), .stall(stall16), .clear(clear16),
        .packet_count(pc16), .last_pkt_bytes(lb16), .last_pkt_beats(lbe16),
        .max_pkt_bytes(mx16), .min_pkt_bytes(mn16), .err_count(er16), .stats_valid(sv16)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int sv_cnt   = 0;

    always @(negedge clk) if (stats_valid) sv_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_stats(input string tag, input logic [63:0] cnt, input logic [63:0] lb,
                                input logic [63:0] lbe, input logic [63:0] mx,
                                input logic [63:0] mn, input logic [63:0] er);
        check({tag, ".packet_count"},   packet_count,   cnt);
        check({tag, ".last_pkt_bytes"}, last_pkt_bytes, lb);
        check({tag, ".last_pkt_beats"}, last_pkt_beats, lbe);
        check({tag, ".max_pkt_bytes"},  max_pkt_bytes,  mx);
        check({tag, ".min_pkt_bytes"},  min_pkt_bytes,  mn);
        check({tag, ".err_count"},      err_count,      er);
        $display("txn %s: count=%0d last=%0d/%0d max=%0d min=%0d err=%0d", tag, packet_count,
                 last_pkt_bytes, last_pkt_beats, max_pkt_bytes, min_pkt_bytes, err_count);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return just after the edge that accepted it.
    task automatic send(input logic [31:0] keep, input logic last);
        bit done;
        int budget;
        done   = 1'b0;
        budget = 0;
        s_if.tdata  = {8{$urandom()}};
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        while (!done) begin
            done = s_if.tready;
            step();
            budget++;
            if (!done && budget > 50) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sv0;
        idle();
        s_if.tdata    = '0;
        s16_if.tdata  = '0;
        s16_if.tkeep  = '0;
        s16_if.tlast  = 1'b0;
        s16_if.tvalid = 1'b0;

        // Reset state
        step(); step();
        check("rst.tready", s_if.tready, 1'b0);
        check("rst.stats_valid", stats_valid, 1'b0);
        expect_stats("rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        check("rst_rel.tready_low", s_if.tready, 1'b0);
        step();
        check("rst_rel.tready_high", s_if.tready, 1'b1);

        // 3-beat packet: 32+32+4 = 68 bytes
        sv0 = sv_cnt;
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_000F, 1'b1);
        idle();
        check("p68.stats_valid", stats_valid, 1'b1);
        expect_stats("p68", 1, 68, 3, 68, 68, 0);
        step();
        check("p68.stats_valid_drop", stats_valid, 1'b0);
        check("p68.sv_pulses", 64'(sv_cnt - sv0), 64'd1);

        // Back-to-back 100, 32, 1 byte packets
        do_clear();
        expect_stats("clr", 0, 0, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_000F, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h0000_0001, 1'b1);
        idle();
        expect_stats("b2b", 3, 1, 1, 100, 1, 0);

        // Two bad tkeep beats in one packet count one error: 31+2 = 33
        do_clear();
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h0000_0005, 1'b1);
        idle();
        expect_stats("err1", 1, 33, 2, 33, 33, 1);

        // Stall for 4 cycles mid-packet
        send(32'hFFFF_FFFF, 1'b0);
        s_if.tvalid = 1'b0;
        stall = 1'b1;
        check("stall.lag", s_if.tready, 1'b1);
        step();
        s_if.tvalid = 1'b1;
        s_if.tkeep  = 32'hFFFF_FFFF;
        s_if.tlast  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("stall.tready_low%0d", i), s_if.tready, 1'b0);
            if (i < 3) step();
        end
        stall = 1'b0;
        check("stall.count_held", packet_count, 64'd1);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'h0000_000F, 1'b1);
        idle();
        expect_stats("stall", 2, 68, 3, 68, 33, 1);

        // Clear together with the second beat of a packet
        send(32'hFFFF_FFFF, 1'b0);
        s_if.tkeep  = 32'hFFFF_FFFF;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        check("clrbeat.tready", s_if.tready, 1'b1);
        do_clear();
        idle();
        expect_stats("clrbeat", 0, 0, 0, 0, 0, 0);
        send(32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        idle();
        expect_stats("p64", 1, 64, 2, 64, 64, 0);

        // Closing-beat tkeep boundaries
        send(32'h0000_0000, 1'b1);
        idle();
        expect_stats("keep0", 2, 0, 1, 64, 0, 1);
        send(32'h0000_0006, 1'b1);
        idle();
        expect_stats("keep6", 3, 2, 1, 64, 0, 2);
        send(32'hFFFF_FFFF, 1'b1);
        idle();
        expect_stats("keepF", 4, 32, 1, 64, 0, 2);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h0000_0000, 1'b1);
        idle();
        expect_stats("multi_err", 5, 62, 3, 64, 0, 3);

        // Reset mid-packet discards the partial packet
        send(32'hFFFF_FFFF, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        check("rstmid.tready", s_if.tready, 1'b0);
        expect_stats("rstmid", 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        check("rstmid.tready_low", s_if.tready, 1'b0);
        step();
        check("rstmid.tready_high", s_if.tready, 1'b1);
        send(32'h0000_0003, 1'b1);
        idle();
        expect_stats("after_rst", 1, 2, 1, 2, 2, 0);

        // 16-bit counters: 65540 one-beat packets saturate packet_count
        rst16 = 1'b0;
        step();
        check("sat.tready", s16_if.tready, 1'b1);
        s16_if.tkeep  = 32'h0000_0001;
        s16_if.tlast  = 1'b1;
        s16_if.tvalid = 1'b1;
        repeat (65540) step();
        s16_if.tvalid = 1'b0;
        check("sat.packet_count", pc16, 16'hFFFF);
        check("sat.last_pkt_bytes", lb16, 16'd1);
        check("sat.max_pkt_bytes", mx16, 16'd1);
        check("sat.err_count", er16, 16'd0);
        $display("txn sat: count=%0h last=%0d max=%0d min=%0d err=%0d", pc16, lb16, mx16, mn16, er16);

        // Reset mid-packet on the 16-bit instance
        s16_if.tkeep  = 32'hFFFF_FFFF;
        s16_if.tlast  = 1'b0;
        s16_if.tvalid = 1'b1;
        step();
        s16_if.tvalid = 1'b0;
        rst16 = 1'b1;
        #1;
        check("rst16.packet_count", pc16, 16'd0);
        check("rst16.last_pkt_bytes", lb16, 16'd0);
        check("rst16.min_pkt_bytes", mn16, 16'd0);
        check("rst16.tready", s16_if.tready, 1'b0);
        step();
        rst16 = 1'b0;
        check("rst16.tready_low", s16_if.tready, 1'b0);
        step();
        check("rst16.tready_high", s16_if.tready, 1'b1);
        $display("txn rst16: count=%0d tready=%0b", pc16, s16_if.tready);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
